// File: rtl/sram_ctrl.sv
// Purpose: sequences one word request from mem into SETUP/ACCESS/HOLD strobes on an async 32-bit SRAM.
// Latency: ready low for WAIT_CYCLES+2 cycles per request; done and read data in the last of them.
// Backpressure: ready=1 only in IDLE; requests seen while busy are ignored, so mem holds sram_ce until done.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   sram_ce/we/addr/sel/wdata      request from mem, accepted on an edge with sram_ce && ready
//   ready, done, rdata             handshake back to mem; rdata holds the last read word
//   ext_addr/dq_o/dq_oe/dq_i       external SRAM address and data pads
//   ext_ce_n/oe_n/we_n/be_n        external SRAM strobes, active low
module sram_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sram_ce,
    input  logic                    sram_we,
    input  logic [ADDR_WIDTH-1:0]   sram_addr,
    input  logic [DATA_WIDTH/8-1:0] sram_sel,
    input  logic [DATA_WIDTH-1:0]   sram_wdata,
    output logic                    ready,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   ext_addr,
    output logic [DATA_WIDTH-1:0]   ext_dq_o,
    output logic                    ext_dq_oe,
    input  logic [DATA_WIDTH-1:0]   ext_dq_i,
    output logic                    ext_ce_n,
    output logic                    ext_oe_n,
    output logic                    ext_we_n,
    output logic [DATA_WIDTH/8-1:0] ext_be_n
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
    logic [DATA_WIDTH-1:0] ext_dq_o_q, ext_dq_o_d;
    logic                  ext_dq_oe_q, ext_dq_oe_d;
    logic                  ext_ce_n_q, ext_ce_n_d;
    logic                  ext_oe_n_q, ext_oe_n_d;
    logic                  ext_we_n_q, ext_we_n_d;
    logic [SEL_W-1:0]      ext_be_n_q, ext_be_n_d;

    // Every output is computed one cycle ahead so the pads come straight from flops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        ready_d     = ready_q;
        done_d      = done_q;
        rdata_d     = rdata_q;
        ext_addr_d  = ext_addr_q;
        ext_dq_o_d  = ext_dq_o_q;
        ext_dq_oe_d = ext_dq_oe_q;
        ext_ce_n_d  = ext_ce_n_q;
        ext_oe_n_d  = ext_oe_n_q;
        ext_we_n_d  = ext_we_n_q;
        ext_be_n_d  = ext_be_n_q;
        case (state_q)
            S_IDLE: begin
                if (sram_ce && ready_q) begin
                    state_d    = S_SETUP;
                    ready_d    = 1'b0;
                    we_d       = sram_we;
                    ext_addr_d = sram_addr;
                    ext_ce_n_d = 1'b0;
                    if (sram_we) begin
                        ext_dq_o_d  = sram_wdata;
                        ext_dq_oe_d = 1'b1;
                        ext_be_n_d  = ~sram_sel;
                    end else begin
                        ext_oe_n_d = 1'b0;
                        ext_be_n_d = '0;
                    end
                end
            end
            S_SETUP: begin
                // Address and data have had a full cycle to settle before we_n falls.
                state_d = S_ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                if (we_q) begin
                    ext_we_n_d = 1'b0;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d    = S_HOLD;
                    ext_we_n_d = 1'b1;
                    ext_oe_n_d = 1'b1;
                    done_d     = 1'b1;
                    // Sample while oe_n is still low, on the same edge it rises.
                    if (!we_q) begin
                        rdata_d = ext_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                // Address, byte enables and write data stay put through HOLD for hold time.
                state_d     = S_IDLE;
                done_d      = 1'b0;
                ready_d     = 1'b1;
                ext_ce_n_d  = 1'b1;
                ext_be_n_d  = '1;
                ext_dq_oe_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            ext_addr_q  <= '0;
            ext_dq_o_q  <= '0;
            ext_dq_oe_q <= 1'b0;
            ext_ce_n_q  <= 1'b1;
            ext_oe_n_q  <= 1'b1;
            ext_we_n_q  <= 1'b1;
            ext_be_n_q  <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            ext_addr_q  <= ext_addr_d;
            ext_dq_o_q  <= ext_dq_o_d;
            ext_dq_oe_q <= ext_dq_oe_d;
            ext_ce_n_q  <= ext_ce_n_d;
            ext_oe_n_q  <= ext_oe_n_d;
            ext_we_n_q  <= ext_we_n_d;
            ext_be_n_q  <= ext_be_n_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign ext_addr  = ext_addr_q;
    assign ext_dq_o  = ext_dq_o_q;
    assign ext_dq_oe = ext_dq_oe_q;
    assign ext_ce_n  = ext_ce_n_q;
    assign ext_oe_n  = ext_oe_n_q;
    assign ext_we_n  = ext_we_n_q;
    assign ext_be_n  = ext_be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_ce = 1'b0;
    logic        sram_we = 1'b0;
    logic [9:0]  sram_addr = '0;
    logic [3:0]  sram_sel = '0;
    logic [31:0] sram_wdata = '0;
    logic        use1 = 1'b0;
    logic [31:0] ext_dq_i;

    always #5 clk = ~clk;

    // Outputs of the WAIT_CYCLES=2 (0) and WAIT_CYCLES=1 (1) instances.
    logic        rdy0, done0, dqoe0, ce0, oe0, we0;
    logic        rdy1, done1, dqoe1, ce1, oe1, we1;
    logic [31:0] rd0, dq0, rd1, dq1;
    logic [9:0]  ad0, ad1;
    logic [3:0]  be0, be1;

    sram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .sram_ce(sram_ce && !use1), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_sel(sram_sel), .sram_wdata(sram_wdata),
        .ready(rdy0), .done(done0), .rdata(rd0), .ext_addr(ad0), .ext_dq_o(dq0),
        .ext_dq_oe(dqoe0), .ext_dq_i(ext_dq_i), .ext_ce_n(ce0), .ext_oe_n(oe0),
        .ext_we_n(we0), .ext_be_n(be0));

    sram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .sram_ce(sram_ce && use1), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_sel(sram_sel), .sram_wdata(sram_wdata),
        .ready(rdy1), .done(done1), .rdata(rd1), .ext_addr(ad1), .ext_dq_o(dq1),
        .ext_dq_oe(dqoe1), .ext_dq_i(ext_dq_i), .ext_ce_n(ce1), .ext_oe_n(oe1),
        .ext_we_n(we1), .ext_be_n(be1));

    // Observed instance selected by use1; the idle one never drives the SRAM.
    wire        m_ready = use1 ? rdy1  : rdy0;
    wire        m_done  = use1 ? done1 : done0;
    wire [31:0] m_rdata = use1 ? rd1   : rd0;
    wire [9:0]  m_addr  = use1 ? ad1   : ad0;
    wire [31:0] m_dq_o  = use1 ? dq1   : dq0;
    wire        m_dq_oe = use1 ? dqoe1 : dqoe0;
    wire        m_ce_n  = use1 ? ce1   : ce0;
    wire        m_oe_n  = use1 ? oe1   : oe0;
    wire        m_we_n  = use1 ? we1   : we0;
    wire [3:0]  m_be_n  = use1 ? be1   : be0;

    // Behavioural SRAM: byte lane i is data[8i+7:8i], written while we_n is low.
    logic [31:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (!m_ce_n && !m_we_n) begin
            for (int i = 0; i < 4; i++)
                if (!m_be_n[i]) mem[m_addr][8*i +: 8] <= m_dq_o[8*i +: 8];
        end
    end
    assign ext_dq_i = (!m_ce_n && !m_oe_n) ? mem[m_addr] : 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] rdata;
        int          rdy_lo;
        int          we_lo;
        int          oe_lo;
        int          dqoe_hi;
        logic [3:0]  be_n;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];

    function automatic exp_t mk(input logic [9:0] a, input logic [31:0] rd, input int rl,
                                input int wl, input int ol, input int dh, input logic [3:0] b);
        exp_t e;
        e.addr = a; e.rdata = rd; e.rdy_lo = rl; e.we_lo = wl;
        e.oe_lo = ol; e.dqoe_hi = dh; e.be_n = b;
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge, measures each request from
    // the fall of ready to the done pulse, and checks it against the scoreboard head.
    int   cyc = 0;
    logic prev_ready = 1'b1;
    logic active = 1'b0;
    int   c_rdy, c_we, c_oe, c_dqoe, c_both;
    logic [3:0] c_be;
    logic be_first, be_bad;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (prev_ready && !m_ready && !rst) begin
            active = 1'b1; acc_q.push_back(cyc);
            c_rdy = 0; c_we = 0; c_oe = 0; c_dqoe = 0; c_both = 0;
            be_first = 1'b1; be_bad = 1'b0; c_be = 4'h0;
        end
        if (active) begin
            if (!m_ready) c_rdy++;
            if (!m_we_n) c_we++;
            if (!m_oe_n) c_oe++;
            if (!m_we_n && !m_oe_n) c_both++;
            if (m_dq_oe) c_dqoe++;
            if (!m_ce_n) begin
                if (be_first) begin c_be = m_be_n; be_first = 1'b0; end
                else if (c_be !== m_be_n) be_bad = 1'b1;
            end
        end
        if (m_done) begin
            if (!active || sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", m_rdata, e.rdata);
                chk("ext_addr", 32'(m_addr), 32'(e.addr));
                chk("ready_low_cycles", c_rdy, e.rdy_lo);
                chk("we_n_low_cycles", c_we, e.we_lo);
                chk("oe_n_low_cycles", c_oe, e.oe_lo);
                chk("dq_oe_high_cycles", c_dqoe, e.dqoe_hi);
                chk("we_oe_overlap", c_both, 0);
                chk("be_n", {27'h0, be_bad, c_be}, {28'h0, e.be_n});
            end
            active = 1'b0;
        end else if (active && m_ready) begin
            active = 1'b0;   // aborted by reset
        end
        prev_ready = m_ready;
    end

    task automatic req(input logic we, input logic [9:0] a, input logic [3:0] s,
                       input logic [31:0] d, input exp_t e);
        int t;
        @(negedge clk);
        sb.push_back(e);
        sram_ce = 1'b1; sram_we = we; sram_addr = a; sram_sel = s; sram_wdata = d;
        @(negedge clk);
        sram_ce = 1'b0;
        t = 0;
        while (!m_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("req_timeout", 32'(t < 50), 1);
    endtask

    initial begin
        int t;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_ready", m_ready, 1);
        chk("rst_done", m_done, 0);
        chk("rst_ce_n", m_ce_n, 1);
        chk("rst_oe_n", m_oe_n, 1);
        chk("rst_we_n", m_we_n, 1);
        chk("rst_be_n", m_be_n, 4'hF);
        chk("rst_dq_oe", m_dq_oe, 0);
        chk("rst_addr", 32'(m_addr), 0);
        chk("rst_dq_o", m_dq_o, 0);
        chk("rst_rdata", m_rdata, 0);
        rst = 1'b0;

        //  we  addr  sel    wdata             addr  rdata        rl we oe dq be_n
        req(1, 10'd5, 4'hF, 32'h12345678, mk(10'd5, 32'h0,        4, 2, 0, 4, 4'h0));
        req(0, 10'd5, 4'h0, 32'h0,        mk(10'd5, 32'h12345678, 4, 0, 3, 0, 4'h0));
        req(1, 10'd5, 4'h8, 32'hAAAAAAAA, mk(10'd5, 32'h12345678, 4, 2, 0, 4, 4'h7));
        req(0, 10'd5, 4'h0, 32'h0,        mk(10'd5, 32'hAA345678, 4, 0, 3, 0, 4'h0));
        req(1, 10'd5, 4'h0, 32'h55555555, mk(10'd5, 32'hAA345678, 4, 2, 0, 4, 4'hF));
        req(0, 10'd5, 4'h0, 32'h0,        mk(10'd5, 32'hAA345678, 4, 0, 3, 0, 4'h0));
        req(1, 10'd7, 4'hF, 32'h0BADF00D, mk(10'd7, 32'hAA345678, 4, 2, 0, 4, 4'h0));

        // sram_ce held high: two reads 5 cycles apart, address changed while busy.
        @(negedge clk);
        acc_q.delete();
        sb.push_back(mk(10'd5, 32'hAA345678, 4, 0, 3, 0, 4'h0));
        sb.push_back(mk(10'd7, 32'h0BADF00D, 4, 0, 3, 0, 4'h0));
        sram_ce = 1'b1; sram_we = 1'b0; sram_addr = 10'd5;
        t = 0;
        while (acc_q.size() < 2 && t < 50) begin
            @(negedge clk);
            t++;
            if (acc_q.size() >= 1) sram_addr = 10'd7;
        end
        sram_ce = 1'b0;
        chk("held_ce_accepts", acc_q.size(), 2);
        if (acc_q.size() >= 2) chk("accept_spacing", acc_q[1] - acc_q[0], 5);
        t = 0;
        while ((sb.size() != 0 || !m_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("held_ce_drain", sb.size(), 0);

        // Reset in the second ACCESS cycle of a write.
        @(negedge clk);
        sram_ce = 1'b1; sram_we = 1'b1; sram_addr = 10'd9; sram_sel = 4'hF;
        sram_wdata = 32'hDEADBEEF;
        @(negedge clk);
        sram_ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_n", m_we_n, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_we_n", m_we_n, 1);
        chk("abort_ce_n", m_ce_n, 1);
        chk("abort_dq_oe", m_dq_oe, 0);
        chk("abort_ready", m_ready, 1);
        chk("abort_done", m_done, 0);
        chk("abort_rdata", m_rdata, 0);
        repeat (6) @(negedge clk);

        // WAIT_CYCLES=1 instance: shorter read.
        use1 = 1'b1;
        req(0, 10'd5, 4'h0, 32'h0, mk(10'd5, 32'hAA345678, 3, 0, 2, 0, 4'h0));
        repeat (3) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
